// File: rtl/char_input_device_if.sv
// CPU bus seen by a memory-mapped device slot: request from the CPU,
// one-cycle registered response and a level interrupt from the device.
interface char_input_device_if;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport master (
        output valid, address, wstrobe, wdata,
        input  rdata, ready, irq
    );

    modport slave (
        input  valid, address, wstrobe, wdata,
        output rdata, ready, irq
    );
endinterface

// File: rtl/char_input_device.sv
// Character input device: bytes pushed on a stream port are queued in a FIFO
// and handed to the CPU through reads of a DATA register.
module char_input_device #(
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    char_input_device_if.slave  bus,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RESPOND} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic            irq_enable_reg, irq_enable_next;
    logic            irq_reg;
    logic [31:0]     rdata_reg, rdata_next;

    logic            ready;
    logic            load_rdata;
    logic            full;
    logic            push;
    logic            pop;
    logic            access_done;
    logic            is_write;
    logic [1:0]      reg_sel;
    logic [7:0]      head;
    logic            unused_bits;

    assign unused_bits = ^{bus.address[31:4], bus.address[1:0], bus.wdata[31:1]};

    // Responder FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Responder FSM: next state
    always_comb begin
        state_next = IDLE;
        if (state_reg == IDLE && bus.valid) state_next = RESPOND;
    end

    // Responder FSM: outputs
    always_comb begin
        ready      = (state_reg == RESPOND);
        load_rdata = (state_reg == IDLE) && bus.valid;
    end

    assign reg_sel     = bus.address[3:2];
    assign is_write    = (bus.wstrobe != 4'h0);
    assign access_done = bus.valid && ready;

    assign full     = (count_reg == FULL_COUNT);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign pop      = access_done && !is_write && reg_sel == 2'd0 && count_reg != '0;

    always_comb begin
        count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // A refused push in the same cycle as a STATUS write leaves overflow set.
    always_comb begin
        overflow_next = overflow_reg;
        if (access_done && is_write && reg_sel == 2'd1) overflow_next = 1'b0;
        if (in_valid && full)                           overflow_next = 1'b1;
    end

    always_comb begin
        irq_enable_next = irq_enable_reg;
        if (access_done && is_write && reg_sel == 2'd2 && bus.wstrobe[0])
            irq_enable_next = bus.wdata[0];
    end

    // The response shows the state after this edge, so a byte landing in an
    // empty FIFO now is forwarded straight from the push port.
    assign head = (count_reg == '0 && push) ? in_data : mem[rd_ptr_reg];

    always_comb begin
        rdata_next = rdata_reg;
        if (load_rdata) begin
            case (reg_sel)
                2'd0:    rdata_next = (count_next != '0) ? {24'h0, head} : 32'hFFFF_FFFF;
                2'd1:    rdata_next = {16'h0, 8'(count_next), 5'h0, overflow_next,
                                       count_next == FULL_COUNT, count_next != '0};
                2'd2:    rdata_next = {31'h0, irq_enable_next};
                default: rdata_next = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            irq_enable_reg <= 1'b0;
            irq_reg        <= 1'b0;
            rdata_reg      <= 32'h0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            irq_enable_reg <= irq_enable_next;
            irq_reg        <= irq_enable_reg && count_reg != '0;
            rdata_reg      <= rdata_next;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.ready = ready;
    assign bus.irq   = irq_reg;
endmodule

// File: tb/tb_char_input_device.sv
// Directed and random checks of char_input_device against a queue-based model
// that is advanced once per clock edge.
module tb_char_input_device;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       in_ready;

    char_input_device_if bif();

    char_input_device #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  q[$];
    bit          m_ovf = 0;
    bit          m_irq_en = 0;
    bit          m_irq = 0;
    bit          m_ready = 0;
    logic [31:0] m_rdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return (q.size() != 0) ? {24'h0, q[0]} : 32'hFFFF_FFFF;
            2'd1:    return {16'h0, 8'(q.size()), 5'h0, m_ovf, q.size() == DEPTH, q.size() != 0};
            2'd2:    return {31'h0, m_irq_en};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: advance the model with the inputs present at the edge,
    // then compare every output on the following falling edge.
    task automatic step();
        int         cnt;
        bit         full, done, wr, irq_n, ready_n;
        logic [1:0] sel;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf = 0; m_irq_en = 0; m_irq = 0; m_ready = 0; m_rdata = 32'h0;
        end else begin
            cnt     = q.size();
            full    = (cnt == DEPTH);
            done    = m_ready && bif.valid;
            wr      = (bif.wstrobe != 4'h0);
            sel     = bif.address[3:2];
            irq_n   = m_irq_en && cnt != 0;
            ready_n = bif.valid && !m_ready;
            if (done && wr && sel == 2'd1) m_ovf = 0;
            if (in_valid && full) m_ovf = 1;
            if (done && wr && sel == 2'd2 && bif.wstrobe[0]) m_irq_en = bif.wdata[0];
            if (done && !wr && sel == 2'd0 && cnt != 0) void'(q.pop_front());
            if (in_valid && !full) q.push_back(in_data);
            m_irq   = irq_n;
            m_ready = ready_n;
            if (ready_n) m_rdata = reg_value(sel);
        end
        @(negedge clk);
        check("ready",    {31'h0, bif.ready}, {31'h0, m_ready});
        check("rdata",    bif.rdata, m_rdata);
        check("irq",      {31'h0, bif.irq}, {31'h0, m_irq});
        check("in_ready", {31'h0, in_ready}, {31'h0, !reset && q.size() != DEPTH});
    endtask

    task automatic access(input logic [31:0] addr, input logic [3:0] strobe,
                          input logic [31:0] data, input bit hold, output logic [31:0] r);
        bif.valid = 1'b1; bif.address = addr; bif.wstrobe = strobe; bif.wdata = data;
        step();
        check("latency", {31'h0, bif.ready}, 32'h1);
        r = bif.rdata;
        step();
        if (!hold) begin
            bif.valid = 1'b0; bif.wstrobe = 4'h0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] r;
    logic [7:0]  sent;
    bit          done_now;

    initial begin
        bif.valid = 1'b0; bif.address = 32'h0; bif.wstrobe = 4'h0; bif.wdata = 32'h0;
        step(); step();
        reset = 1'b0;
        step();
        access(32'h0, 4'h0, 0, 0, r);
        access(32'h4, 4'h0, 0, 0, r);
        check("reset_status", r, 32'h0);

        push(8'h41); push(8'h42); push(8'h43);
        access(32'h0, 4'h0, 0, 1, r); check("data_41", r, 32'h41);
        access(32'h0, 4'h0, 0, 1, r); check("data_42", r, 32'h42);
        access(32'h0, 4'h0, 0, 1, r); check("data_43", r, 32'h43);
        access(32'h0, 4'h0, 0, 0, r); check("data_empty", r, 32'hFFFF_FFFF);

        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
            if (i == 15) check("full_in_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid = 1'b0;
        access(32'hAB00_0004, 4'h0, 0, 0, r); check("status_full", r, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            access(32'h0, 4'h0, 0, 0, r); check("drain", r, 32'(i));
        end
        access(32'h4, 4'hF, 32'h0, 0, r);
        access(32'h4, 4'h0, 0, 0, r); check("ovf_cleared", r, 32'h0);

        access(32'h8, 4'h1, 32'h1, 0, r);
        step(); step(); check("irq_empty", {31'h0, bif.irq}, 32'h0);
        push(8'h55);
        check("irq_p1", {31'h0, bif.irq}, 32'h0);
        step(); check("irq_p2", {31'h0, bif.irq}, 32'h1);
        access(32'h0, 4'h0, 0, 0, r); check("data_55", r, 32'h55);
        step(); check("irq_after_pop", {31'h0, bif.irq}, 32'h0);
        access(32'h8, 4'h1, 32'h0, 0, r);

        for (int i = 0; i < 40; i++) begin
            sent = 8'($urandom);
            push(sent);
            access(32'h0, 4'h0, 0, 0, r); check("wrap", r, {24'h0, sent});
        end

        push(8'h01); push(8'h02); push(8'h03);
        bif.valid = 1'b1; bif.address = 32'h0; bif.wstrobe = 4'h0;
        step();
        in_valid = 1'b1; in_data = 8'h04;
        step();
        in_valid = 1'b0; bif.valid = 1'b0;
        access(32'h4, 4'h0, 0, 0, r); check("push_pop_count", r, 32'h0000_0301);
        for (int i = 2; i <= 4; i++) begin
            access(32'h0, 4'h0, 0, 0, r); check("push_pop_data", r, 32'(i));
        end

        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0) && (c % 400 < 300);
            in_data  = 8'($urandom);
            if (!bif.valid && $urandom_range(0, 2) != 0) begin
                bif.valid   = 1'b1;
                bif.address = $urandom;
                if ($urandom_range(0, 3) == 0) bif.address[3:2] = 2'd0;
                bif.wstrobe = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
                bif.wdata   = $urandom;
            end
            done_now = bif.valid && m_ready;
            step();
            if (done_now && $urandom_range(0, 1) == 0) begin
                bif.valid = 1'b0; bif.wstrobe = 4'h0;
            end
        end
        in_valid = 1'b0; bif.valid = 1'b0; bif.wstrobe = 4'h0;
        step(); step();
        reset = 1'b1; step(); reset = 1'b0; step();

        push(8'h61); push(8'h62); push(8'h63);
        bif.valid = 1'b1; bif.address = 32'h0; bif.wstrobe = 4'h0;
        step();
        reset = 1'b1;
        step();
        check("reset_abort_ready", {31'h0, bif.ready}, 32'h0);
        reset = 1'b0; bif.valid = 1'b0;
        step();
        access(32'h4, 4'h0, 0, 0, r); check("reset_status_empty", r, 32'h0);
        access(32'h0, 4'h0, 0, 0, r); check("reset_no_byte", r, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/char_input_device.md
# char_input_device

Memory-mapped character input device: a bus responder that buffers bytes arriving on a byte-stream push port in a FIFO and hands them to the CPU through reads of a data register. It is the input counterpart of the write-only text output device. It sits on a device slot of the CPU bus, selected by the address decoder on `address[31:24]`, and can raise `bus.irq` when characters are pending.

## Interface
- `DEPTH`, 16: FIFO capacity in bytes; power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bus`  Bus.s  —  responder side of the CPU bus (`valid`, `address`, `wstrobe`, `wdata`, `rdata`, `ready`, `irq`).
- `in_valid`  in  1  producer has a byte on `in_data`.
- `in_data`  in  8  byte to enqueue.
- `in_ready`  out  1  device accepts a byte this cycle; a push happens when `in_valid && in_ready`.

## Operation
- Register map, decoded on `address[3:2]`. Upper address bits are ignored.
  - 0x0 DATA, read-only.
    - Non-empty: `rdata = {24'h0, head}` and the head is popped.
    - Empty: `rdata = 32'hFFFF_FFFF`, no pop.
  - 0x4 STATUS.
    - Read: bit0 = non-empty, bit1 = full, bit2 = overflow (sticky), bits[15:8] = count, other bits 0.
    - Any write clears overflow.
  - 0x8 CONTROL, read/write: bit0 = irq_enable. Other bits read 0.
  - 0xC: reads 0, writes ignored.
- An access is a write when `wstrobe != 0`; otherwise it is a read. Writes to DATA are ignored. CONTROL bit0 is written only when `wstrobe[0]` is set.
- FIFO: circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - `in_ready = !reset && count != DEPTH`.
  - Push when full is refused. If `in_valid` is high while full, overflow is set and the byte is dropped.
  - Push and pop in the same cycle: count unchanged, both pointers advance. A full FIFO does not accept a push even if a pop happens that cycle.
- `bus.irq` is a register: `irq_enable && count != 0`, updated every cycle.
- Reset values: `rdata` = 0, `ready` = 0, `irq` = 0, irq_enable = 0, overflow = 0, count = 0, pointers = 0. Stored FIFO data is not cleared.
- Reset mid-transaction: any pending response is aborted. `ready` is 0 on the cycle after reset, and the FIFO is emptied.

## Timing
- Responder state: IDLE / RESPOND, held as a registered `ready`.
  - IDLE → RESPOND when `valid && !ready`.
  - RESPOND → IDLE unconditionally.
  - `ready` is high for exactly one cycle per access.
- Latency: `valid` asserted in cycle N gives `ready = 1` with `rdata` in cycle N+1.
- The DATA pop and the register write take effect at the end of cycle N+1 (the edge where `valid && ready`).
- `rdata` and STATUS reflect state as of the start of cycle N+1. A push landing in cycle N+1 is not visible to that read.
- `valid` held high continuously gives one response every 2 cycles. No response ever occurs without `valid`.
- `rdata` holds its value outside RESPOND.
- IRQ reflects a pop or push one cycle after the edge that changes count.

## Test plan
- Reset, then read STATUS → `rdata = 0`. `in_ready = 1`, `bus.irq = 0` from the first post-reset cycle.
- Push 0x41, 0x42, 0x43, then read DATA four times → 0x41, 0x42, 0x43, 0xFFFF_FFFF. Each `ready` arrives exactly 1 cycle after `valid`, with a 1-cycle gap when `valid` is held high.
- Push 17 bytes 0x00..0x10 with DEPTH = 16:
  - `in_ready = 0` after the 16th push.
  - STATUS reads 0x0000_1007.
  - Drain returns 0x00..0x0F.
  - Write STATUS → overflow reads 0.
- Write CONTROL = 1 with the FIFO empty → irq stays 0. Push 0x55 → irq = 1 two cycles later. Read DATA → 0x55, and irq = 0 one cycle after the pop edge.
- Wrap and simultaneous events:
  - Push/pop 40 bytes interleaved so the pointers wrap twice; the order is preserved.
  - A push in the same cycle as a DATA read pop leaves count unchanged.
- Assert reset during RESPOND of a DATA read with 3 bytes queued → `ready = 0` next cycle, STATUS reads 0, and no byte is returned.
